// File: rtl/jump_redirect_ctrl_pkg.sv
// Shared constants and types for the jump redirect controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package jump_redirect_pkg;

  localparam int ADDR_W           = 32;
  localparam int SEL_W            = 32;
  localparam int FLUSH_CYCLES_DEF = 3;

  // Controller state encoding, kept as plain constants for legacy tools
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_REQ   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  // Redirect payload handed to fetch
  typedef struct packed {
    logic [ADDR_W-1:0] eip;
    logic              load_cs;
    logic [SEL_W-1:0]  cs;
  } redirect_t;

  // Drain counter width; at least one bit so a zero-length drain still elaborates
  function automatic int drain_cnt_width(input int flush_cycles);
    return (flush_cycles < 1) ? 1 : $clog2(flush_cycles + 1);
  endfunction

endpackage

// File: rtl/jump_redirect_ctrl_if.sv
// Execute-side result bus plus fetch-side redirect handshake.
// Latency: n/a (wires only).
// Backpressure: ex_ready towards execute, redirect_ack from fetch.
interface jump_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  // execute side
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] next_eip;
  logic        jump_load_address;
  logic [31:0] jump_address;
  logic        jump_load_cs;
  logic [31:0] jump_cs;
  logic        br_misprediction;
  // fetch side
  logic        redirect_valid;
  logic        redirect_ack;
  logic [31:0] redirect_eip;
  logic        redirect_load_cs;
  logic [31:0] redirect_cs;
  // pipeline control / status
  logic             flush;
  logic [CNT_W-1:0] redirect_count;

  // Environment: execute unit and fetch unit
  modport master (
    output ex_valid, next_eip, jump_load_address, jump_address,
           jump_load_cs, jump_cs, br_misprediction, redirect_ack,
    input  ex_ready, redirect_valid, redirect_eip, redirect_load_cs,
           redirect_cs, flush, redirect_count
  );

  // The redirect controller
  modport slave (
    input  ex_valid, next_eip, jump_load_address, jump_address,
           jump_load_cs, jump_cs, br_misprediction, redirect_ack,
    output ex_ready, redirect_valid, redirect_eip, redirect_load_cs,
           redirect_cs, flush, redirect_count
  );
endinterface

// File: rtl/jump_redirect_ctrl_flush_drain_cnt.sv
// Loadable down-counter timing the post-ack flush window.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; holds at zero when decremented past it.
module flush_drain_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // load has priority over decrement; never wraps below zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Turns resolved jumps/mispredicts into a held redirect request plus flush window.
// Latency: redirect_valid/flush rise one cycle after the triggering execute beat.
// Backpressure: ex_ready low from trigger until drain ends; payload held until ack.
module jump_redirect_ctrl
  import jump_redirect_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  jump_redirect_ctrl_if.slave   bus
);

  localparam int DW = drain_cnt_width(FLUSH_CYCLES);
  // First drain cycle already counts as one of the FLUSH_CYCLES
  localparam logic [DW-1:0] DRAIN_LOAD = (FLUSH_CYCLES > 0) ? DW'(FLUSH_CYCLES - 1) : '0;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             need_redirect;
  logic             ack_fire;
  logic             drain_load;
  logic             drain_dec;
  logic             drain_zero;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] count_q;
  redirect_t        payload;
  redirect_t        payload_nxt;

  assign bus.ex_ready = (state == ST_IDLE) && reset;

  assign need_redirect = bus.ex_valid && bus.ex_ready &&
                         (bus.jump_load_address || bus.jump_load_cs || bus.br_misprediction);

  // An ack only counts while a request is actually being presented
  assign ack_fire = (state == ST_REQ) && bus.redirect_ack;

  assign drain_load = ack_fire && (FLUSH_CYCLES > 0);
  assign drain_dec  = (state == ST_DRAIN);

  flush_drain_cnt #(.W(DW)) u_drain (
    .clk      (clk),
    .reset    (reset),
    .load     (drain_load),
    .load_val (DRAIN_LOAD),
    .dec      (drain_dec),
    .cnt      (drain_cnt),
    .zero     (drain_zero)
  );

  // Next-state decode; the unused encoding falls back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (need_redirect) state_nxt = ST_REQ;
      ST_REQ:   if (ack_fire)      state_nxt = (FLUSH_CYCLES > 0) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (drain_zero)    state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Target select: explicit jump wins, otherwise a mispredict falls through
  always_comb begin
    payload_nxt.eip     = bus.jump_load_address ? bus.jump_address : bus.next_eip;
    payload_nxt.load_cs = bus.jump_load_cs;
    payload_nxt.cs      = bus.jump_load_cs ? bus.jump_cs : '0;
  end

  // Payload is only rewritten on a new trigger so it stays stable through REQ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      payload <= '0;
    end else if (need_redirect) begin
      payload <= payload_nxt;
    end
  end

  // Redirect event counter, free-running wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (ack_fire) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.redirect_valid   = (state == ST_REQ);
  assign bus.flush            = (state == ST_REQ) || (state == ST_DRAIN);
  assign bus.redirect_eip     = payload.eip;
  assign bus.redirect_load_cs = payload.load_cs;
  assign bus.redirect_cs      = payload.cs;
  assign bus.redirect_count   = count_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl: default build plus a FLUSH_CYCLES=0, CNT_W=2 build.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: execute holds ex_valid while ex_ready is low.
module tb_jump_redirect_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  jump_redirect_ctrl_if #(.CNT_W(16)) a ();
  jump_redirect_ctrl_if #(.CNT_W(2))  b ();

  jump_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  jump_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic jla, input logic [31:0] ja,
                         input logic jlcs, input logic [31:0] jcs,
                         input logic brm, input logic [31:0] ne);
    a.ex_valid          = v;
    a.jump_load_address = jla;
    a.jump_address      = ja;
    a.jump_load_cs      = jlcs;
    a.jump_cs           = jcs;
    a.br_misprediction  = brm;
    a.next_eip          = ne;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    a.redirect_ack       = 1'b0;
    b.ex_valid           = 1'b0;
    b.jump_load_address  = 1'b0;
    b.jump_address       = 32'h0;
    b.jump_load_cs       = 1'b0;
    b.jump_cs            = 32'h0;
    b.br_misprediction   = 1'b0;
    b.next_eip           = 32'h0;
    b.redirect_ack       = 1'b0;

    // ---- reset state ----
    #3;
    chk("rst_ex_ready", {31'h0, a.ex_ready}, 32'h0);
    chk("rst_valid",    {31'h0, a.redirect_valid}, 32'h0);
    chk("rst_flush",    {31'h0, a.flush}, 32'h0);
    chk("rst_eip",      a.redirect_eip, 32'h0);
    chk("rst_cs",       a.redirect_cs, 32'h0);
    chk("rst_count",    {16'h0, a.redirect_count}, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("idle_ex_ready", {31'h0, a.ex_ready}, 32'h1);

    // ---- far jump, ack on second REQ cycle ----
    drive_a(1'b1, 1'b1, 32'h0000_1234, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0050);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("far_valid",   {31'h0, a.redirect_valid}, 32'h1);
    chk("far_eip",     a.redirect_eip, 32'h0000_1234);
    chk("far_load_cs", {31'h0, a.redirect_load_cs}, 32'h1);
    chk("far_cs",      a.redirect_cs, 32'h0000_0008);
    chk("far_flush",   {31'h0, a.flush}, 32'h1);
    chk("far_ex_ready", {31'h0, a.ex_ready}, 32'h0);
    step();
    chk("far_valid_hold", {31'h0, a.redirect_valid}, 32'h1);
    chk("far_eip_hold",   a.redirect_eip, 32'h0000_1234);
    a.redirect_ack = 1'b1;
    step();
    a.redirect_ack = 1'b0;
    chk("far_valid_drop", {31'h0, a.redirect_valid}, 32'h0);
    chk("far_count",      {16'h0, a.redirect_count}, 32'h1);
    chk("far_drain1",     {31'h0, a.flush}, 32'h1);
    step();
    chk("far_drain2",     {31'h0, a.flush}, 32'h1);
    step();
    chk("far_drain3",     {31'h0, a.flush}, 32'h1);
    step();
    chk("far_flush_end",  {31'h0, a.flush}, 32'h0);
    chk("far_ex_ready_back", {31'h0, a.ex_ready}, 32'h1);
    chk("far_eip_kept",   a.redirect_eip, 32'h0000_1234);

    // ---- stray ack in IDLE is ignored ----
    a.redirect_ack = 1'b1;
    step();
    a.redirect_ack = 1'b0;
    chk("stray_ack_count", {16'h0, a.redirect_count}, 32'h1);
    chk("stray_ack_valid", {31'h0, a.redirect_valid}, 32'h0);

    // ---- not-taken mispredict, ack in first REQ cycle ----
    drive_a(1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 32'h0000_0055, 1'b1, 32'h0000_0102);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mis_valid",   {31'h0, a.redirect_valid}, 32'h1);
    chk("mis_eip",     a.redirect_eip, 32'h0000_0102);
    chk("mis_load_cs", {31'h0, a.redirect_load_cs}, 32'h0);
    chk("mis_cs",      a.redirect_cs, 32'h0);
    a.redirect_ack = 1'b1;
    step();
    a.redirect_ack = 1'b0;
    chk("mis_count",   {16'h0, a.redirect_count}, 32'h2);
    chk("mis_valid_drop", {31'h0, a.redirect_valid}, 32'h0);
    step();
    step();
    step();
    chk("mis_idle", {31'h0, a.ex_ready}, 32'h1);

    // ---- plain instructions: no redirect ----
    drive_a(1'b1, 1'b0, 32'h0000_7777, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_0200);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("nored_valid",    {31'h0, a.redirect_valid}, 32'h0);
      chk("nored_flush",    {31'h0, a.flush}, 32'h0);
      chk("nored_ex_ready", {31'h0, a.ex_ready}, 32'h1);
    end
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("nored_count", {16'h0, a.redirect_count}, 32'h2);
    chk("nored_eip",   a.redirect_eip, 32'h0000_0102);

    // ---- back-pressure: second trigger held across REQ/DRAIN ----
    drive_a(1'b1, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    drive_a(1'b1, 1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("bp_eip1",     a.redirect_eip, 32'h0000_1000);
    chk("bp_ready_req", {31'h0, a.ex_ready}, 32'h0);
    step();
    chk("bp_eip1_stable", a.redirect_eip, 32'h0000_1000);
    a.redirect_ack = 1'b1;
    step();
    a.redirect_ack = 1'b0;
    chk("bp_count3",   {16'h0, a.redirect_count}, 32'h3);
    chk("bp_ready_d1", {31'h0, a.ex_ready}, 32'h0);
    chk("bp_eip_drain", a.redirect_eip, 32'h0000_1000);
    step();
    step();
    chk("bp_ready_d3", {31'h0, a.ex_ready}, 32'h0);
    step();
    chk("bp_ready_idle", {31'h0, a.ex_ready}, 32'h1);
    chk("bp_flush_idle", {31'h0, a.flush}, 32'h0);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("bp_valid2", {31'h0, a.redirect_valid}, 32'h1);
    chk("bp_eip2",   a.redirect_eip, 32'h0000_2000);
    a.redirect_ack = 1'b1;
    step();
    a.redirect_ack = 1'b0;
    chk("bp_count4", {16'h0, a.redirect_count}, 32'h4);
    step();
    step();
    step();
    chk("bp_done", {31'h0, a.ex_ready}, 32'h1);

    // ---- reset during REQ ----
    drive_a(1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mid_valid", {31'h0, a.redirect_valid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, a.redirect_valid}, 32'h0);
    chk("mid_rst_flush", {31'h0, a.flush}, 32'h0);
    chk("mid_rst_eip",   a.redirect_eip, 32'h0);
    chk("mid_rst_cs",    a.redirect_cs, 32'h0);
    chk("mid_rst_lcs",   {31'h0, a.redirect_load_cs}, 32'h0);
    chk("mid_rst_count", {16'h0, a.redirect_count}, 32'h0);
    chk("mid_rst_ready", {31'h0, a.ex_ready}, 32'h0);
    step();
    reset = 1'b1;
    step();
    chk("mid_rel_ready", {31'h0, a.ex_ready}, 32'h1);
    chk("mid_rel_valid", {31'h0, a.redirect_valid}, 32'h0);
    drive_a(1'b1, 1'b1, 32'h0000_0044, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mid_next_eip", a.redirect_eip, 32'h0000_0044);
    a.redirect_ack = 1'b1;
    step();
    a.redirect_ack = 1'b0;
    chk("mid_next_count", {16'h0, a.redirect_count}, 32'h1);

    // ---- FLUSH_CYCLES=0 / CNT_W=2 build: no drain, counter wraps ----
    for (int i = 0; i < 5; i++) begin
      b.ex_valid          = 1'b1;
      b.jump_load_address = 1'b1;
      b.jump_address      = 32'h0000_0100 + 32'(i);
      step();
      b.ex_valid          = 1'b0;
      b.jump_load_address = 1'b0;
      chk("nf_valid", {31'h0, b.redirect_valid}, 32'h1);
      chk("nf_eip",   b.redirect_eip, 32'h0000_0100 + 32'(i));
      b.redirect_ack = 1'b1;
      step();
      b.redirect_ack = 1'b0;
      chk("nf_flush_off", {31'h0, b.flush}, 32'h0);
      chk("nf_ready",     {31'h0, b.ex_ready}, 32'h1);
      chk("nf_count",     {30'h0, b.redirect_count}, 32'((i + 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case something upstream never returns
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach end, checks %0d", checks);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jump_redirect_ctrl.md
Name: jump_redirect_ctrl

Overview:
- Sits directly downstream of the execute-stage jump unit.
- Captures its resolved control-transfer results (jump_load_address, jump_address, jump_load_cs, jump_cs, br_misprediction).
- Converts them into a registered, handshaked redirect request to fetch, plus a pipeline flush window that drains wrong-path instructions from decode/execute.
- Stalls execute while a redirect is outstanding.

Parameters:
- FLUSH_CYCLES, 3, cycles flush stays asserted after fetch acknowledges the redirect (0 = no drain window).
- CNT_W, 16, width of the redirect event counter.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents a resolved instruction this cycle
- ex_ready  out  1  block can accept the execute result
- next_eip  in  32  fall-through EIP of the resolved instruction
- jump_load_address  in  1  execute requests EIP load
- jump_address  in  32  target EIP
- jump_load_cs  in  1  far jump, CS load requested
- jump_cs  in  32  target CS
- br_misprediction  in  1  predicted direction differs from resolved direction
- redirect_valid  out  1  redirect request to fetch
- redirect_ack  in  1  fetch accepts the redirect
- redirect_eip  out  32  new fetch EIP
- redirect_load_cs  out  1  fetch must also load CS
- redirect_cs  out  32  new CS
- flush  out  1  squash all younger instructions in decode/execute
- redirect_count  out  CNT_W  number of redirects accepted by fetch

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; redirect_valid=0, redirect_eip=0, redirect_cs=0, redirect_load_cs=0, flush=0, redirect_count=0, drain counter=0. ex_ready=0 while reset is low. Reset mid-request or mid-drain abandons the operation immediately with no ack required.
- ex_ready = (state==IDLE) and reset high. Combinational from state only; never from ex_valid.
- Trigger: need_redirect = ex_valid & ex_ready & (jump_load_address | jump_load_cs | br_misprediction).
- Target select on trigger:
  - jump_load_address=1 → redirect_eip=jump_address.
  - else (misprediction only, predicted taken, resolved not-taken) → redirect_eip=next_eip.
  - redirect_load_cs=jump_load_cs; redirect_cs=jump_cs if jump_load_cs, else 0.
- Accepted ex_valid without need_redirect: no state change, no outputs.
- States:
  - IDLE: on need_redirect, register target/CS, go to REQ next edge. redirect_valid=1 and flush=1 from the next cycle (1-cycle latency).
  - REQ: redirect_valid=1, flush=1, payload held stable. On redirect_ack:
    - redirect_count increments; wraps from all-ones to 0, no saturation.
    - redirect_valid drops next cycle.
    - FLUSH_CYCLES>0 → DRAIN with counter=FLUSH_CYCLES-1.
    - FLUSH_CYCLES=0 → IDLE.
  - DRAIN: flush=1, redirect_valid=0. Counter decrements each cycle; at counter==0, go to IDLE next edge. Flush is high for exactly FLUSH_CYCLES cycles after the ack cycle.
- Edge cases:
  - redirect_ack while redirect_valid=0 is ignored.
  - ex_valid in REQ/DRAIN is not accepted (ex_ready=0); execute must hold it.
  - Ack in the first REQ cycle is legal; minimum trigger-to-IDLE = 2+FLUSH_CYCLES cycles.
  - Payload outputs keep their last values in DRAIN/IDLE until the next trigger; only redirect_valid qualifies them.

Decomposition:
- Shared package (jump_redirect_pkg):
  - state encoding IDLE=2'b00, REQ=2'b01, DRAIN=2'b10
  - FLUSH_CYCLES default
  - 32-bit address/selector width constants
- One sub-module, flush_drain_cnt: loadable down-counter with load, dec, and zero flag; width clog2(FLUSH_CYCLES+1).
- FSM, payload registers and event counter stay in the top module.

Test Plan:
- Far jump: ex_valid=1, jump_load_address=1, jump_address=0x0000_1234, jump_load_cs=1, jump_cs=0x0000_0008; ack 2 cycles later → next cycle redirect_valid=1, redirect_eip=0x1234, redirect_load_cs=1, redirect_cs=0x8; flush high through 3 cycles post-ack; redirect_count=1; ex_ready returns 1.
- Not-taken mispredict: br_misprediction=1, jump_load_address=0, next_eip=0x0000_0102 → redirect_eip=0x102, redirect_load_cs=0, redirect_cs=0.
- No redirect: ex_valid=1 with all three triggers 0 for 10 cycles → redirect_valid and flush stay 0, ex_ready stays 1, count unchanged.
- Back-pressure: a second trigger (jump_address=0x2000) held during REQ/DRAIN of the first (0x1000) → ex_ready=0 until IDLE; then captured and issued as redirect_eip=0x2000; count=2.
- Reset mid-op: reset low during REQ, then release → all outputs 0, state IDLE, no ack needed; next trigger proceeds normally.
- Boundaries:
  - redirect_count preset to 0xFFFF via 65535 redirects, or a shortened-CNT_W build → next ack wraps to 0.
  - FLUSH_CYCLES=0 build → flush deasserts the cycle after ack.
